// File: rtl/ahb_lite_arbiter2.sv
// Two-master AHB-Lite arbiter in front of a single shared slave.
// Address phase is routed from a combinational grant; data phase follows the registered owner.
module ahb_lite_arbiter2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] M0_HADDR,
    input  logic [31:0] M0_HWDATA,
    input  logic [2:0]  M0_HBURST,
    input  logic [2:0]  M0_HSIZE,
    input  logic [1:0]  M0_HTRANS,
    input  logic        M0_HSEL,
    input  logic        M0_HWRITE,
    output logic [31:0] M0_HRDATA,
    output logic        M0_HREADY,
    output logic        M0_HRESP,
    input  logic [31:0] M1_HADDR,
    input  logic [31:0] M1_HWDATA,
    input  logic [2:0]  M1_HBURST,
    input  logic [2:0]  M1_HSIZE,
    input  logic [1:0]  M1_HTRANS,
    input  logic        M1_HSEL,
    input  logic        M1_HWRITE,
    output logic [31:0] M1_HRDATA,
    output logic        M1_HREADY,
    output logic        M1_HRESP,
    output logic [31:0] S_HADDR,
    output logic [2:0]  S_HBURST,
    output logic [2:0]  S_HSIZE,
    output logic [1:0]  S_HTRANS,
    output logic        S_HSEL,
    output logic        S_HWRITE,
    output logic [31:0] S_HWDATA,
    input  logic [31:0] S_HRDATA,
    input  logic        S_HREADY,
    input  logic        S_HRESP,
    output logic [1:0]  GRANT
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    logic       req0, req1;
    logic       grant_m1;
    logic       last_m1;     // round-robin history: master of the last accepted transfer
    logic       park_m1;     // idle grant target; same as last_m1 except out of reset
    logic       d_valid;
    logic       d_owner;
    logic       lock_reg;
    logic       lock_incr;
    logic [3:0] beats;
    logic [1:0] owner_trans;
    logic       lock_active;
    logic       accept;
    logic [1:0] g_trans;
    logic [2:0] g_burst;
    logic       g_sel;

    assign req0 = M0_HSEL & M0_HTRANS[1];
    assign req1 = M1_HSEL & M1_HTRANS[1];

    // Lock survives only while the owner keeps its burst going with SEQ/BUSY.
    assign owner_trans = last_m1 ? M1_HTRANS : M0_HTRANS;
    assign lock_active = lock_reg && ((owner_trans == TR_SEQ) || (owner_trans == TR_BUSY));

    always_comb begin
        grant_m1 = park_m1;
        if (lock_active)
            grant_m1 = last_m1;
        else if (req0 && !req1)
            grant_m1 = 1'b0;
        else if (req1 && !req0)
            grant_m1 = 1'b1;
        else if (req0 && req1)
            grant_m1 = FIXED_PRIO ? 1'b0 : !last_m1;
    end

    assign GRANT   = grant_m1 ? 2'b10 : 2'b01;
    assign g_trans = grant_m1 ? M1_HTRANS : M0_HTRANS;
    assign g_burst = grant_m1 ? M1_HBURST : M0_HBURST;
    assign g_sel   = grant_m1 ? M1_HSEL   : M0_HSEL;
    assign accept  = S_HREADY && (grant_m1 ? req1 : req0);

    assign S_HADDR  = grant_m1 ? M1_HADDR  : M0_HADDR;
    assign S_HSIZE  = grant_m1 ? M1_HSIZE  : M0_HSIZE;
    assign S_HWRITE = grant_m1 ? M1_HWRITE : M0_HWRITE;
    assign S_HBURST = g_burst;
    assign S_HSEL   = g_sel;
    assign S_HTRANS = g_sel ? g_trans : TR_IDLE;
    assign S_HWDATA = d_owner ? M1_HWDATA : M0_HWDATA;

    assign M0_HRDATA = S_HRDATA;
    assign M1_HRDATA = S_HRDATA;

    assign M0_HREADY = ((d_valid && !d_owner) || !grant_m1) ? S_HREADY : !req0;
    assign M1_HREADY = ((d_valid &&  d_owner) ||  grant_m1) ? S_HREADY : !req1;
    assign M0_HRESP  = d_valid && !d_owner && S_HRESP;
    assign M1_HRESP  = d_valid &&  d_owner && S_HRESP;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            last_m1 <= 1'b1;
            park_m1 <= 1'b0;
            d_valid <= 1'b0;
            d_owner <= 1'b0;
        end else if (S_HREADY) begin
            if (accept) begin
                d_owner <= grant_m1;
                d_valid <= 1'b1;
                last_m1 <= grant_m1;
                park_m1 <= grant_m1;
            end else begin
                d_valid <= 1'b0;
            end
        end
    end

    // An error response, or the owner dropping out of SEQ/BUSY, releases the lock.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            lock_reg  <= 1'b0;
            lock_incr <= 1'b0;
            beats     <= 4'd0;
        end else if (S_HRESP) begin
            lock_reg  <= 1'b0;
            lock_incr <= 1'b0;
        end else if (accept && (g_trans == TR_NONSEQ)) begin
            case (g_burst)
                3'd1: begin
                    lock_reg  <= 1'b1;
                    lock_incr <= 1'b1;
                    beats     <= 4'd0;
                end
                3'd2, 3'd3: begin
                    lock_reg  <= 1'b1;
                    lock_incr <= 1'b0;
                    beats     <= 4'd3;
                end
                3'd4, 3'd5: begin
                    lock_reg  <= 1'b1;
                    lock_incr <= 1'b0;
                    beats     <= 4'd7;
                end
                3'd6, 3'd7: begin
                    lock_reg  <= 1'b1;
                    lock_incr <= 1'b0;
                    beats     <= 4'd15;
                end
                default: begin
                    lock_reg  <= 1'b0;
                    lock_incr <= 1'b0;
                    beats     <= 4'd0;
                end
            endcase
        end else if (accept && (g_trans == TR_SEQ) && lock_reg && !lock_incr) begin
            beats <= beats - 4'd1;
            if (beats == 4'd1) lock_reg <= 1'b0;
        end else if (lock_reg && !lock_active) begin
            lock_reg  <= 1'b0;
            lock_incr <= 1'b0;
        end
    end

endmodule

// File: doc/ahb_lite_arbiter2.md
AHB_LITE_ARBITER2 -- requirements
Module: ahb_lite_arbiter2

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0, meaning 0 = round-robin and 1 = M0 always wins a tie.
REQ-002 SHALL have port HCLK, input, 1 bit: single clock for all logic.
REQ-003 SHALL have port HRESETn, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have ports Mx_HADDR/Mx_HWDATA (x=0,1), input, 32 bits each: master address and write data.
REQ-005 SHALL have ports Mx_HBURST input 3, Mx_HSIZE input 3, Mx_HTRANS input 2, Mx_HSEL input 1, Mx_HWRITE input 1: master controls.
REQ-006 SHALL have ports Mx_HRDATA output 32, Mx_HREADY output 1, Mx_HRESP output 1: per-master responses.
REQ-007 SHALL have ports S_HADDR 32, S_HBURST 3, S_HSIZE 3, S_HTRANS 2, S_HSEL 1, S_HWRITE 1, S_HWDATA 32, all outputs: shared slave (ahb_lite_sdram) side.
REQ-008 SHALL have ports S_HRDATA 32, S_HREADY 1, S_HRESP 1, all inputs: slave responses.
REQ-009 SHALL have port GRANT, output, 2 bits: one-hot address-phase owner, bit0 = M0.

Function
REQ-010 SHALL define req[x] = Mx_HSEL & Mx_HTRANS[1].
REQ-011 SHALL compute grant combinationally: the lock owner if lock is active, else the sole requester, else on a tie M0 if FIXED_PRIO=1 or the master not last accepted, else park on the last owner.
REQ-012 SHALL route the granted master's HADDR/HBURST/HSIZE/HWRITE to S_*, with S_HTRANS = granted HTRANS if its HSEL is 1 else IDLE(0), and S_HSEL = granted HSEL.
REQ-013 SHALL accept an address phase when S_HREADY=1 and req[grant]=1; on acceptance register d_owner<=grant, d_valid<=1 and last<=grant; on S_HREADY=1 with no request register d_valid<=0.
REQ-014 SHALL drive S_HWDATA from Mx_HWDATA of d_owner and broadcast S_HRDATA to both Mx_HRDATA.
REQ-015 SHALL drive Mx_HREADY = S_HREADY if x is the data owner (d_valid) or the granted master; else 0 if req[x]; else 1.
REQ-016 SHALL drive Mx_HRESP = S_HRESP when d_valid and d_owner=x, else 0.
REQ-017 SHALL load lock_reg=1 and beats=L-1 on an accepted NONSEQ with HBURST giving L = 4 (WRAP4/INCR4), 8 (WRAP8/INCR8) or 16 (WRAP16/INCR16); SINGLE gives no lock.
REQ-018 SHALL hold lock_reg with no count on an accepted NONSEQ with HBURST=INCR (1).
REQ-019 SHALL decrement beats on each accepted SEQ and clear lock_reg when beats reaches 0; BUSY passes to the slave and does not decrement.
REQ-020 SHALL treat lock as active only while lock_reg=1 and the owner's HTRANS is SEQ or BUSY; an owner IDLE/NONSEQ ends the lock, which early-terminates the burst.
REQ-021 SHALL clear lock_reg when S_HRESP=1.
REQ-022 SHALL add zero wait states for an uncontended master; a losing master stalls with its address phase held.
REQ-023 SHALL never drop or duplicate an address phase; each accepted transfer reaches the slave exactly once.

Reset
REQ-024 SHALL on HRESETn=0, at any time including mid-burst, set last=M1 (so M0 wins the first tie), d_valid=0, lock_reg=0, beats=0, GRANT=2'b01.
REQ-025 SHALL in reset drive S_HTRANS=IDLE, S_HSEL=0, Mx_HREADY=1 and Mx_HRESP=0 when no master requests.

Verification
REQ-026 SHALL check: only M0 issues SINGLE write 0x10=0xA5A5A5A5 -> S_HTRANS=NONSEQ the same cycle, M0_HREADY follows S_HREADY, and a readback returns 0xA5A5A5A5.
REQ-027 SHALL check: both masters issue NONSEQ SINGLE in the first cycle after reset -> M0 is accepted first, M1_HREADY=0 until M0's data phase ends, then M1 is accepted.
REQ-028 SHALL check: M0 issues WRAP4 while M1 requests from beat 2 -> GRANT stays 01 for all 4 beats, then M1 is granted on the next S_HREADY=1.
REQ-029 SHALL check: both masters request SINGLE continuously -> grants alternate M0,M1,M0,M1 with FIXED_PRIO=0, and are all M0 with FIXED_PRIO=1.
REQ-030 SHALL check: HRESETn is asserted during beat 2 of an M1 INCR8 -> all outputs return to the REQ-024/025 values immediately and M0 is granted first after release.
REQ-031 SHALL check: the slave returns HRESP=1 mid-burst -> only the owner sees HRESP, the lock is released, and the other master is granted next.
